// File: rtl/ov7670_dvp_emulator.sv
// OV7670-style DVP transmitter in RGB444 mode.
// Produces the sensor's vsync/href/pixel-byte timing from the pclk domain.
// Every register changes on the falling pclk edge so that a receiver
// sampling on the rising edge sees stable data. Outputs are registered
// copies of values computed from the next state. They therefore line up
// exactly with the state and counter registers.
module ov7670_dvp_emulator #(
    parameter int unsigned H_PIX       = 640,
    parameter int unsigned V_ROWS      = 480,
    parameter int unsigned H_BLANK     = 288,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned VBP_LINES   = 17,
    parameter int unsigned VFP_LINES   = 10,
    parameter logic [11:0] LFSR_SEED   = 12'hACE
) (
    input  logic        i_pclk,
    input  logic        i_rstn_pclk,
    input  logic        i_start,
    input  logic        i_continuous,
    input  logic [1:0]  i_pattern_sel,
    input  logic [11:0] i_solid_rgb,
    output logic        o_pix_vsync,
    output logic        o_pix_href,
    output logic [7:0]  o_pix_byte,
    output logic        o_frame_done,
    output logic        o_busy
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        if (a > b) begin
            max2 = a;
        end else begin
            max2 = b;
        end
    endfunction

    // 12-bit Fibonacci LFSR, x^12+x^11+x^10+x^4+1; a nonzero state never maps to zero
    function automatic logic [11:0] lfsr_next(input logic [11:0] s);
        lfsr_next = {s[10:0], s[11] ^ s[10] ^ s[9] ^ s[3]};
    endfunction

    // Colour of each of the eight vertical bars, left to right
    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            3'd7:    bar_rgb = 12'h000;
            default: bar_rgb = 12'h000;
        endcase
    endfunction

    localparam int unsigned T_LINE  = 2 * H_PIX + H_BLANK;
    localparam int unsigned VS_LEN  = VSYNC_LINES * T_LINE;
    localparam int unsigned VBP_LEN = VBP_LINES * T_LINE;
    localparam int unsigned VFP_LEN = VFP_LINES * T_LINE;
    localparam int unsigned ACT_LEN = 2 * H_PIX;
    localparam int unsigned MAX_LEN = max2(max2(max2(VS_LEN, VBP_LEN), max2(VFP_LEN, ACT_LEN)), H_BLANK);

    localparam int unsigned CNT_W = max2($clog2(MAX_LEN), 1);
    localparam int unsigned ROW_W = max2($clog2(V_ROWS), 1);
    localparam int unsigned COL_W = max2($clog2(H_PIX), 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(VS_LEN - 1);
    localparam logic [CNT_W-1:0] VBP_LAST   = CNT_W'(VBP_LEN - 1);
    localparam logic [CNT_W-1:0] VFP_LAST   = CNT_W'(VFP_LEN - 1);
    localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(ACT_LEN - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO   = ROW_W'(0);
    localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(V_ROWS - 1);
    localparam logic [COL_W-1:0] COL_ZERO   = COL_W'(0);
    localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
    // Bar width in pixels; clamped to 1 so tiny test geometries stay legal
    localparam logic [15:0]      BAR_DIV    = 16'(max2(H_PIX / 8, 1));

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_VSYNC     = 3'd1,
        S_VBP       = 3'd2,
        S_ROW_ACT   = 3'd3,
        S_ROW_BLANK = 3'd4,
        S_VFP       = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [11:0]        lfsr_q, lfsr_d;
    logic [1:0]         sel_q, sel_d;
    logic [11:0]        solid_q, solid_d;
    logic               vsync_q, vsync_d;
    logic               href_q, href_d;
    logic [7:0]         byte_q, byte_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               start_frame_s;
    logic [15:0]        col16_s;
    logic [15:0]        bar16_s;
    logic [2:0]         bar_s;
    logic [11:0]        rgb_s;

    // Next-state, interval counters and per-frame latches
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        row_d         = row_q;
        col_d         = col_q;
        lfsr_d        = lfsr_q;
        sel_d         = sel_q;
        solid_d       = solid_q;
        start_frame_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    start_frame_s = 1'b1;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            S_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    state_d = S_VBP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_VBP: begin
                if (cnt_q == VBP_LAST) begin
                    state_d = S_ROW_ACT;
                    cnt_d   = CNT_ZERO;
                    col_d   = COL_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ROW_ACT: begin
                // The odd byte closes a pixel: step the LFSR for the next one
                if (cnt_q[0]) begin
                    lfsr_d = lfsr_next(lfsr_q);
                end else begin
                    lfsr_d = lfsr_q;
                end
                if (cnt_q == ACT_LAST) begin
                    state_d = S_ROW_BLANK;
                    cnt_d   = CNT_ZERO;
                    col_d   = COL_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q[0]) begin
                        col_d = col_q + COL_ONE;
                    end else begin
                        col_d = col_q;
                    end
                end
            end
            S_ROW_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (row_q == ROW_LAST) begin
                        state_d = S_VFP;
                    end else begin
                        state_d = S_ROW_ACT;
                        row_d   = row_q + ROW_ONE;
                        col_d   = COL_ZERO;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_VFP: begin
                if (cnt_q == VFP_LAST) begin
                    if (i_continuous && i_start) begin
                        start_frame_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Frame entry: clear position, reseed, and capture the pattern choice
        if (start_frame_s) begin
            state_d = S_VSYNC;
            cnt_d   = CNT_ZERO;
            row_d   = ROW_ZERO;
            col_d   = COL_ZERO;
            lfsr_d  = LFSR_SEED;
            sel_d   = i_pattern_sel;
            solid_d = i_solid_rgb;
        end else begin
            sel_d   = sel_q;
        end
    end

    // Pixel colour and output values for the cycle about to be presented
    always_comb begin
        col16_s = 16'(col_d);
        bar16_s = col16_s / BAR_DIV;
        if (bar16_s > 16'd7) begin
            bar_s = 3'd7;
        end else begin
            bar_s = bar16_s[2:0];
        end

        case (sel_d)
            2'd0:    rgb_s = bar_rgb(bar_s);
            2'd1:    rgb_s = {col16_s[5:2], col16_s[5:2], col16_s[5:2]};
            2'd2:    rgb_s = lfsr_d;
            2'd3:    rgb_s = solid_d;
            default: rgb_s = solid_d;
        endcase

        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ROW_ACT);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_VFP) && (cnt_d == VFP_LAST);

        // Even byte carries red with a fixed high nibble, odd byte carries green/blue
        if (href_d) begin
            if (cnt_d[0]) begin
                byte_d = rgb_s[7:0];
            end else begin
                byte_d = {4'hF, rgb_s[11:8]};
            end
        end else begin
            byte_d = 8'h00;
        end
    end

    // State, counters and output registers, all on the falling pclk edge
    always_ff @(negedge i_pclk or negedge i_rstn_pclk) begin
        if (!i_rstn_pclk) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            row_q   <= ROW_ZERO;
            col_q   <= COL_ZERO;
            lfsr_q  <= 12'h000;
            sel_q   <= 2'd0;
            solid_q <= 12'h000;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            byte_q  <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lfsr_q  <= lfsr_d;
            sel_q   <= sel_d;
            solid_q <= solid_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign o_pix_vsync  = vsync_q;
    assign o_pix_href   = href_q;
    assign o_pix_byte   = byte_q;
    assign o_frame_done = done_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_ov7670_dvp_emulator.sv
// Bench for ov7670_dvp_emulator with a reduced geometry.
// Expected pixel bytes are queued when a frame is requested. They are
// consumed as href bytes arrive on the rising pclk edge.
`timescale 1ns/1ps
module tb_ov7670_dvp_emulator;

    localparam int H_PIX       = 64;
    localparam int V_ROWS      = 4;
    localparam int H_BLANK     = 6;
    localparam int VSYNC_LINES = 2;
    localparam int VBP_LINES   = 1;
    localparam int VFP_LINES   = 1;
    localparam int T_LINE      = 2 * H_PIX + H_BLANK;
    localparam int VS_LEN      = VSYNC_LINES * T_LINE;
    localparam int FIRST_HREF  = (VSYNC_LINES + VBP_LINES) * T_LINE;
    localparam int FRAME_LEN   = (VSYNC_LINES + VBP_LINES + V_ROWS + VFP_LINES) * T_LINE;
    localparam int BAR_W       = H_PIX / 8;

    logic        i_pclk        = 1'b0;
    logic        i_rstn_pclk   = 1'b0;
    logic        i_start       = 1'b0;
    logic        i_continuous  = 1'b0;
    logic [1:0]  i_pattern_sel = 2'd0;
    logic [11:0] i_solid_rgb   = 12'h000;
    logic        o_pix_vsync;
    logic        o_pix_href;
    logic [7:0]  o_pix_byte;
    logic        o_frame_done;
    logic        o_busy;

    ov7670_dvp_emulator #(
        .H_PIX(H_PIX), .V_ROWS(V_ROWS), .H_BLANK(H_BLANK),
        .VSYNC_LINES(VSYNC_LINES), .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES),
        .LFSR_SEED(12'hACE)
    ) dut (
        .i_pclk(i_pclk), .i_rstn_pclk(i_rstn_pclk), .i_start(i_start),
        .i_continuous(i_continuous), .i_pattern_sel(i_pattern_sel),
        .i_solid_rgb(i_solid_rgb), .o_pix_vsync(o_pix_vsync),
        .o_pix_href(o_pix_href), .o_pix_byte(o_pix_byte),
        .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 i_pclk = ~i_pclk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    bit   mon_en = 1'b0;

    int cyc = 0, frame_t0 = 0, vs_len = 0, first_href = 0, href_len = 0;
    int href_period = 0, href_pulses = 0, last_href_rise = 0;
    int fd_cnt = 0, fd_at = 0, vs_rises = 0, last_fd_cyc = 0, last_vs_rise = 0;
    logic prev_vs = 1'b0, prev_href = 1'b0;

    // Receiver side: timing statistics plus byte scoreboard
    initial begin : monitor
        forever begin
            @(posedge i_pclk);
            cyc = cyc + 1;
            if (mon_en) begin
                if (o_pix_vsync && !prev_vs) begin
                    frame_t0 = cyc; last_vs_rise = cyc; vs_rises++; href_pulses = 0;
                end
                if (!o_pix_vsync && prev_vs) vs_len = cyc - frame_t0;
                if (o_pix_href && !prev_href) begin
                    if (href_pulses == 0) first_href = cyc - frame_t0;
                    else href_period = cyc - last_href_rise;
                    last_href_rise = cyc;
                    href_pulses++;
                end
                if (!o_pix_href && prev_href) href_len = cyc - last_href_rise;
                if (o_frame_done) begin
                    fd_cnt++; fd_at = cyc - frame_t0 + 1; last_fd_cyc = cyc;
                end
                n_checks++;
                if (o_pix_href) begin
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL byte_unexpected: got %02h at cycle %0d, required no byte", o_pix_byte, cyc);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (o_pix_byte !== exp_b) begin
                            n_fail++;
                            $display("FAIL pix_byte: got %02h, required %02h (cycle %0d)", o_pix_byte, exp_b, cyc);
                        end
                    end
                end else if (o_pix_byte !== 8'h00) begin
                    n_fail++;
                    $display("FAIL byte_blank: got %02h with href low, required 00", o_pix_byte);
                end
            end
            prev_vs   = o_pix_vsync;
            prev_href = o_pix_href;
        end
    end

    // Reference model: queue every byte of one frame
    task automatic push_frame(input logic [1:0] s, input logic [11:0] solid);
        logic [11:0] lf;
        logic [11:0] rgb;
        logic [15:0] c16;
        logic [11:0] bars [8];
        int bar;
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        lf = 12'hACE;
        for (int r = 0; r < V_ROWS; r++) begin
            for (int c = 0; c < H_PIX; c++) begin
                c16 = 16'(c);
                bar = c / BAR_W;
                if (bar > 7) bar = 7;
                case (s)
                    2'd0:    rgb = bars[bar];
                    2'd1:    rgb = {c16[5:2], c16[5:2], c16[5:2]};
                    2'd2:    rgb = lf;
                    default: rgb = solid;
                endcase
                exp_q.push_back({4'hF, rgb[11:8]});
                exp_q.push_back(rgb[7:0]);
                lf = {lf[10:0], lf[11] ^ lf[10] ^ lf[9] ^ lf[3]};
            end
        end
    endtask

    task automatic wait_busy(input string name);
        for (int i = 0; i < 4 && !o_busy; i++) begin @(posedge i_pclk); #1; end
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL %s_busy_rise: busy %b, required 1", name, o_busy);
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (fd_cnt < target && n < budget) begin @(posedge i_pclk); #1; n++; end
        n_checks++;
        if (fd_cnt < target) begin
            n_fail++; $display("FAIL %s_timeout: frame_done count %0d, required %0d", name, fd_cnt, target);
        end
    endtask

    // Launch one non-continuous frame and wait for it to finish
    task automatic run_frame(input logic [1:0] s, input logic [11:0] solid, input string name);
        int fd0;
        fd0 = fd_cnt;
        push_frame(s, solid);
        @(posedge i_pclk); #1;
        i_pattern_sel = s; i_solid_rgb = solid; i_continuous = 1'b0; i_start = 1'b1;
        wait_busy(name);
        i_start = 1'b0;
        wait_done(fd0 + 1, FRAME_LEN + 20, name);
        repeat (3) @(posedge i_pclk);
        #1;
    endtask

    task automatic test_reset();
        i_rstn_pclk = 1'b0;
        repeat (3) @(posedge i_pclk);
        #1;
        n_checks += 5;
        if (o_pix_vsync !== 1'b0) begin n_fail++; $display("FAIL rst_vsync: got %b, required 0", o_pix_vsync); end
        if (o_pix_href !== 1'b0) begin n_fail++; $display("FAIL rst_href: got %b, required 0", o_pix_href); end
        if (o_pix_byte !== 8'h00) begin n_fail++; $display("FAIL rst_byte: got %02h, required 00", o_pix_byte); end
        if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", o_frame_done); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
        i_rstn_pclk = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(posedge i_pclk);
        #1;
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", o_busy); end
    endtask

    task automatic test_solid_timing();
        int vr0, fd0;
        vr0 = vs_rises; fd0 = fd_cnt;
        run_frame(2'd3, 12'h5A3, "solid");
        n_checks += 10;
        if (vs_len != VS_LEN) begin n_fail++; $display("FAIL vsync_len: got %0d, required %0d", vs_len, VS_LEN); end
        if (first_href != FIRST_HREF) begin n_fail++; $display("FAIL first_href: got %0d, required %0d", first_href, FIRST_HREF); end
        if (href_len != 2 * H_PIX) begin n_fail++; $display("FAIL href_len: got %0d, required %0d", href_len, 2 * H_PIX); end
        if (href_period != T_LINE) begin n_fail++; $display("FAIL href_period: got %0d, required %0d", href_period, T_LINE); end
        if (href_pulses != V_ROWS) begin n_fail++; $display("FAIL href_pulses: got %0d, required %0d", href_pulses, V_ROWS); end
        if (fd_at != FRAME_LEN) begin n_fail++; $display("FAIL done_cycle: got %0d, required %0d", fd_at, FRAME_LEN); end
        if (fd_cnt != fd0 + 1) begin n_fail++; $display("FAIL done_count: got %0d, required %0d", fd_cnt, fd0 + 1); end
        if (vs_rises != vr0 + 1) begin n_fail++; $display("FAIL solid_vsyncs: got %0d, required %0d", vs_rises, vr0 + 1); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL solid_busy_end: got %b, required 0", o_busy); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL solid_left: %0d bytes not seen, required 0", exp_q.size()); end
    endtask

    task automatic test_colour_bars();
        run_frame(2'd0, 12'h123, "bars");
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bars_left: %0d bytes not seen, required 0", exp_q.size()); end
    endtask

    task automatic test_gradient();
        run_frame(2'd1, 12'h000, "grad");
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL grad_left: %0d bytes not seen, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back_lfsr();
        int vr0, fd0, n;
        vr0 = vs_rises; fd0 = fd_cnt;
        push_frame(2'd2, 12'h000);
        push_frame(2'd2, 12'h000);
        @(posedge i_pclk); #1;
        i_pattern_sel = 2'd2; i_continuous = 1'b1; i_start = 1'b1;
        wait_busy("b2b");
        n = 0;
        while (vs_rises < vr0 + 2 && n < FRAME_LEN + 20) begin @(posedge i_pclk); #1; n++; end
        i_start = 1'b0;
        n_checks += 2;
        if (vs_rises != vr0 + 2) begin n_fail++; $display("FAIL b2b_second_vsync: got %0d, required %0d", vs_rises, vr0 + 2); end
        if (last_vs_rise - last_fd_cyc != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d, required 1", last_vs_rise - last_fd_cyc); end
        wait_done(fd0 + 2, FRAME_LEN + 20, "b2b");
        repeat (T_LINE) @(posedge i_pclk);
        #1;
        n_checks += 4;
        if (vs_rises != vr0 + 2) begin n_fail++; $display("FAIL b2b_vsyncs: got %0d, required %0d", vs_rises, vr0 + 2); end
        if (fd_cnt != fd0 + 2) begin n_fail++; $display("FAIL b2b_done: got %0d, required %0d", fd_cnt, fd0 + 2); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b, required 0", o_busy); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_left: %0d bytes not seen, required 0", exp_q.size()); end
        i_continuous = 1'b0;
    endtask

    task automatic test_reset_mid_row();
        int vr0, fd0, n;
        push_frame(2'd3, 12'h3C7);
        @(posedge i_pclk); #1;
        i_pattern_sel = 2'd3; i_solid_rgb = 12'h3C7; i_start = 1'b1;
        n = 0;
        while (!o_pix_href && n < FIRST_HREF + 20) begin @(posedge i_pclk); #1; n++; end
        repeat (5) @(posedge i_pclk);
        #1;
        i_rstn_pclk = 1'b0;
        #1;
        n_checks += 4;
        if (o_pix_vsync !== 1'b0) begin n_fail++; $display("FAIL midrst_vsync: got %b, required 0", o_pix_vsync); end
        if (o_pix_href !== 1'b0) begin n_fail++; $display("FAIL midrst_href: got %b, required 0", o_pix_href); end
        if (o_pix_byte !== 8'h00) begin n_fail++; $display("FAIL midrst_byte: got %02h, required 00", o_pix_byte); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", o_busy); end
        exp_q.delete();
        repeat (3) @(posedge i_pclk);
        #1;
        vr0 = vs_rises; fd0 = fd_cnt;
        push_frame(2'd3, 12'h3C7);
        i_rstn_pclk = 1'b1;
        wait_busy("midrst");
        i_start = 1'b0;
        wait_done(fd0 + 1, FRAME_LEN + 20, "midrst");
        repeat (3) @(posedge i_pclk);
        #1;
        n_checks += 4;
        if (vs_len != VS_LEN) begin n_fail++; $display("FAIL midrst_vsync_len: got %0d, required %0d", vs_len, VS_LEN); end
        if (first_href != FIRST_HREF) begin n_fail++; $display("FAIL midrst_first_href: got %0d, required %0d", first_href, FIRST_HREF); end
        if (vs_rises != vr0 + 1) begin n_fail++; $display("FAIL midrst_vsyncs: got %0d, required %0d", vs_rises, vr0 + 1); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_left: %0d bytes not seen, required 0", exp_q.size()); end
    endtask

    task automatic test_continuous_drop();
        int vr0, fd0, n;
        vr0 = vs_rises; fd0 = fd_cnt;
        push_frame(2'd3, 12'h123);
        @(posedge i_pclk); #1;
        i_pattern_sel = 2'd3; i_solid_rgb = 12'h123; i_continuous = 1'b1; i_start = 1'b1;
        n = 0;
        while (!(vs_rises == vr0 + 1 && href_pulses == 3 && o_pix_href) && n < FRAME_LEN) begin
            @(posedge i_pclk); #1; n++;
        end
        repeat (10) @(posedge i_pclk);
        #1;
        i_start = 1'b0; i_pattern_sel = 2'd0; i_solid_rgb = 12'hFFF;
        wait_done(fd0 + 1, FRAME_LEN + 20, "cont");
        repeat (3 * T_LINE) @(posedge i_pclk);
        #1;
        n_checks += 5;
        if (vs_rises != vr0 + 1) begin n_fail++; $display("FAIL cont_vsyncs: got %0d, required %0d", vs_rises, vr0 + 1); end
        if (href_pulses != V_ROWS) begin n_fail++; $display("FAIL cont_rows: got %0d, required %0d", href_pulses, V_ROWS); end
        if (fd_cnt != fd0 + 1) begin n_fail++; $display("FAIL cont_done: got %0d, required %0d", fd_cnt, fd0 + 1); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL cont_busy_end: got %b, required 0", o_busy); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL cont_left: %0d bytes not seen, required 0", exp_q.size()); end
        i_continuous = 1'b0;
    endtask

    initial begin
        test_reset();
        test_solid_timing();
        test_colour_bars();
        test_gradient();
        test_back_to_back_lfsr();
        test_reset_mid_row();
        test_continuous_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
